test_axis_rx_chk: RTL and testbench
===================================

// Module: test_axis_rx_chk
// PURPOSE
//  Parametrised AXI-Stream receive sink/checker for eth_ctrl bring-up benches and on-chip loopback tests.
//  Accepts frames on rx_axis_*, with optional pseudo-random backpressure.
//  Checks payload against an incrementing-byte pattern, frame length against TEST_RX_SIZE, and tkeep legality.
//  Exposes saturating frame/byte/error counters and a sticky error flag for ILA or register readout.
// PARAMETERS
//  AXIS_DATA_WIDTH  64    tdata width in bits; multiple of 8, >= 8
//  TEST_RX_SIZE     1024  expected frame length in bytes; >= 1
//  CNT_WIDTH        32    width of every statistics counter
//  READY_MODE       0     0: tready held high; 1: LFSR-throttled tready (about 75% duty)
//  CHECK_DATA       1     1: enable payload pattern check; 0: payload ignored, err_data_cnt stays 0
// PORTS
//  clk             in   1              single clock
//  rstn            in   1              synchronous, active-low reset
//  rx_axis_tdata   in   AXIS_DATA_WIDTH    stream data; byte lane i = tdata[8i+7:8i]
//  rx_axis_tkeep   in   AXIS_DATA_WIDTH/8  byte-valid mask
//  rx_axis_tvalid  in   1              beat valid
//  rx_axis_tlast   in   1              last beat of frame
//  rx_axis_tready  out  1              registered ready
//  stat_clr        in   1              synchronous clear of counters and err_sticky
//  frame_cnt       out  CNT_WIDTH      frames completed (tlast accepted)
//  byte_cnt        out  CNT_WIDTH      bytes accepted (sum of tkeep popcounts)
//  err_data_cnt    out  CNT_WIDTH      beats with at least one pattern-mismatched valid byte
//  err_len_cnt     out  CNT_WIDTH      frames whose length != TEST_RX_SIZE
//  err_keep_cnt    out  CNT_WIDTH      beats with illegal tkeep
//  in_frame        out  1              high between first and last accepted beat of a frame
//  err_sticky      out  1              set on any error increment; cleared by rstn or stat_clr
// BEHAVIOUR
//  Reset (rstn=0 at clk edge): all outputs 0, including rx_axis_tready; FSM=IDLE; beat_cnt=0; LFSR=16'hACE1.
//  Beat accepted ("xfer") = tvalid & tready at the clk edge. No other input is sampled when xfer=0.
//  tready, READY_MODE=0: 1 from the first cycle after reset release.
//  tready, READY_MODE=1: 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle out of reset; tready <= lfsr[0]|lfsr[1].
//  FSM: IDLE --xfer&!tlast--> RECV; RECV --xfer&tlast--> IDLE.
//       A single-beat frame (xfer&tlast in IDLE) stays in IDLE. in_frame = (state==RECV).
//  beat_cnt: 0 at frame start, +1 per non-last xfer; saturates at all-ones.
//       Width $clog2(2*TEST_RX_SIZE/(AXIS_DATA_WIDTH/8)+2). Cleared on tlast.
//  byte_off = beat_cnt*(AXIS_DATA_WIDTH/8).
//  Data check: valid lane i must equal (byte_off+i)[7:0]; one err_data_cnt increment per bad beat, not per byte.
//  Length check on the tlast beat: byte_off + popcount(tkeep) != TEST_RX_SIZE -> err_len_cnt+1.
//       A saturated beat_cnt always yields a length error.
//  Keep check: a non-last beat needs tkeep all-ones; a last beat needs tkeep != 0 and contiguous from LSB (2^n-1).
//       Violation -> err_keep_cnt+1. The data check still uses the lanes flagged in tkeep.
//  Latency: every counter and err_sticky reflects an xfer on the next clk edge (1 cycle). No combinational path input->output.
//  Counters saturate at 2^CNT_WIDTH-1 and never wrap. byte_cnt saturates rather than adding partially.
//  stat_clr: has priority over a same-cycle increment (result 0). Does not touch the FSM, beat_cnt or tready.
//  Reset mid-frame: the FSM returns to IDLE. The next accepted beat is treated as the start of a new frame, so a partial frame is neither counted nor flagged.
//  tvalid low mid-frame is legal; no timeout.
// STRUCTURE
//  Package test_axis_pkg holds:
//   - rx_state_t enum {IDLE, RECV}
//   - LFSR_SEED=16'hACE1 and the tap mask
//   - functions popcount(keep) and keep_is_contig(keep)
//   - sat_inc(cnt, inc) for saturating add
//  One sub-module, axis_ready_throttle (LFSR + registered ready, READY_MODE param), is shared with the future tx generator.
// TESTING
//  W=64: 1 frame, 128 beats, correct pattern, tkeep=FF
//    -> frame_cnt=1, byte_cnt=1024, all err=0, err_sticky=0.
//  Frame of 1020 bytes, last tkeep=0x0F
//    -> err_len_cnt=1, err_keep_cnt=0, byte_cnt=1020.
//  Beat 5 lane 3 corrupted to 0x00 (expected 0x2B)
//    -> err_data_cnt=1 one cycle after that xfer; err_sticky=1.
//  Non-last beat with tkeep=0x7F, then last beat with tkeep=0x05
//    -> err_keep_cnt=2.
//  READY_MODE=1, 10 back-to-back frames, tvalid held high
//    -> tready duty 70-80%, frame_cnt=10, no errors, and no beat accepted while tready=0.
//  rstn pulsed low after 40 beats, then a full good frame
//    -> frame_cnt=1, err_len_cnt=0.
//  Separately: stat_clr asserted in the same cycle as a tlast xfer -> frame_cnt=0.

Source files
------------

// File: rtl/test_axis_pkg.sv
// Shared types, constants and helpers for the AXI-Stream test sink/generator blocks.
//   rx_state_t      : receive framing state
//   LFSR_SEED/TAPS  : 16-bit Fibonacci LFSR seed and feedback mask (x^16+x^14+x^13+x^11+1)
//   popcount        : number of set bits in a (zero-extended) tkeep vector
//   keep_is_contig  : tkeep non-zero and contiguous from bit 0 (2^n-1)
//   sat_inc         : saturating add for counters up to CNT_MAX_W bits
package test_axis_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Feedback taken from bits 16,14,13,11 (1-based), i.e. bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  // Helper argument widths; callers zero-extend their vectors into these.
  localparam int unsigned KEEP_MAX_W = 128;
  localparam int unsigned CNT_MAX_W  = 64;

  // Count the valid byte lanes in a keep mask.
  function automatic int unsigned popcount(input logic [KEEP_MAX_W-1:0] keep);
    int unsigned n;
    n = 0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      n += 32'(keep[i]);
    end
    return n;
  endfunction

  // Legal final-beat keep: at least one lane, all lanes packed from lane 0.
  function automatic logic keep_is_contig(input logic [KEEP_MAX_W-1:0] keep);
    return (keep != '0) && ((keep & (keep + KEEP_MAX_W'(1))) == '0);
  endfunction

  // Add inc to cnt, clamping at 2^width-1 instead of wrapping or adding partially.
  function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] cnt,
                                                   input logic [CNT_MAX_W-1:0] inc,
                                                   input int unsigned          width);
    logic [CNT_MAX_W-1:0] max_v;
    max_v = (width >= CNT_MAX_W) ? '1 : ((CNT_MAX_W'(1) << width) - CNT_MAX_W'(1));
    if (inc > (max_v - cnt)) begin
      return max_v;
    end
    return cnt + inc;
  endfunction

endpackage

// File: rtl/test_axis_rx_chk_throttle.sv
// Registered tready source, shared by the test stream sink and generator.
//   clk, rstn : clock, synchronous active-low reset
//   ready     : registered ready; constant 1 (READY_MODE=0) or LFSR-throttled ~75% (READY_MODE=1)
module axis_ready_throttle
  import test_axis_pkg::*;
#(
  parameter int unsigned READY_MODE = 0
) (
  input  logic clk,
  input  logic rstn,
  output logic ready
);

  logic [15:0] lfsr;

  // LFSR runs every cycle out of reset; ready is low only when two successive output bits are 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lfsr  <= LFSR_SEED;
      ready <= 1'b0;
    end else begin
      lfsr  <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      ready <= (READY_MODE == 0) ? 1'b1 : (lfsr[0] | lfsr[1]);
    end
  end

endmodule

// File: rtl/test_axis_rx_chk.sv
// AXI-Stream receive sink/checker: accepts frames, checks incrementing-byte payload,
// frame length and tkeep legality, and keeps saturating statistics.
//   clk, rstn        : clock, synchronous active-low reset
//   rx_axis_*        : input stream (tready registered, optionally throttled)
//   stat_clr         : synchronous clear of counters and err_sticky (FSM untouched)
//   frame_cnt        : frames completed          byte_cnt     : bytes accepted
//   err_data_cnt     : beats with bad payload    err_len_cnt  : frames with wrong length
//   err_keep_cnt     : beats with illegal tkeep  in_frame     : mid-frame indicator
//   err_sticky       : any error since last clear
module test_axis_rx_chk
  import test_axis_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH = 64,
  parameter int unsigned TEST_RX_SIZE    = 1024,
  parameter int unsigned CNT_WIDTH       = 32,
  parameter int unsigned READY_MODE      = 0,
  parameter int unsigned CHECK_DATA      = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [AXIS_DATA_WIDTH-1:0]   rx_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] rx_axis_tkeep,
  input  logic                         rx_axis_tvalid,
  input  logic                         rx_axis_tlast,
  output logic                         rx_axis_tready,
  input  logic                         stat_clr,
  output logic [CNT_WIDTH-1:0]         frame_cnt,
  output logic [CNT_WIDTH-1:0]         byte_cnt,
  output logic [CNT_WIDTH-1:0]         err_data_cnt,
  output logic [CNT_WIDTH-1:0]         err_len_cnt,
  output logic [CNT_WIDTH-1:0]         err_keep_cnt,
  output logic                         in_frame,
  output logic                         err_sticky
);

  localparam int unsigned KEEP_W = AXIS_DATA_WIDTH / 8;
  localparam int unsigned BEAT_W = $clog2(2 * TEST_RX_SIZE / KEEP_W + 2);

  rx_state_t         state;
  rx_state_t         state_nxt;
  logic [BEAT_W-1:0] beat_cnt;
  logic              xfer;
  logic [31:0]       byte_off;
  logic [31:0]       keep_pop;
  logic              data_bad;
  logic              keep_bad;
  logic              len_bad;

  axis_ready_throttle #(
    .READY_MODE (READY_MODE)
  ) u_throttle (
    .clk   (clk),
    .rstn  (rstn),
    .ready (rx_axis_tready)
  );

  assign xfer = rx_axis_tvalid & rx_axis_tready;

  // Per-beat checks; only consumed when xfer is high.
  always_comb begin
    byte_off = 32'(beat_cnt) * 32'(KEEP_W);
    keep_pop = 32'(popcount(KEEP_MAX_W'(rx_axis_tkeep)));
    data_bad = 1'b0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (rx_axis_tkeep[i] && (rx_axis_tdata[8*i +: 8] != 8'(byte_off + 32'(i)))) begin
        data_bad = 1'b1;
      end
    end
    if (CHECK_DATA == 0) begin
      data_bad = 1'b0;
    end
    keep_bad = rx_axis_tlast ? !keep_is_contig(KEEP_MAX_W'(rx_axis_tkeep))
                             : (rx_axis_tkeep != '1);
    // A saturated beat count means the true length is unknown, so always flag it.
    len_bad  = rx_axis_tlast && ((beat_cnt == '1) || ((byte_off + keep_pop) != TEST_RX_SIZE));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && !rx_axis_tlast) state_nxt = RECV;
      RECV:    if (xfer && rx_axis_tlast)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State outputs.
  always_comb begin
    in_frame = 1'b0;
    if (state == RECV) begin
      in_frame = 1'b1;
    end
  end

  // Beat position within the current frame; unaffected by stat_clr.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      beat_cnt <= '0;
    end else if (xfer) begin
      if (rx_axis_tlast) begin
        beat_cnt <= '0;
      end else if (beat_cnt != '1) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end

  // Statistics; stat_clr wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rstn || stat_clr) begin
      frame_cnt    <= '0;
      byte_cnt     <= '0;
      err_data_cnt <= '0;
      err_len_cnt  <= '0;
      err_keep_cnt <= '0;
      err_sticky   <= 1'b0;
    end else if (xfer) begin
      frame_cnt    <= CNT_WIDTH'(sat_inc(CNT_MAX_W'(frame_cnt), CNT_MAX_W'(rx_axis_tlast), CNT_WIDTH));
      byte_cnt     <= CNT_WIDTH'(sat_inc(CNT_MAX_W'(byte_cnt), CNT_MAX_W'(keep_pop), CNT_WIDTH));
      err_data_cnt <= CNT_WIDTH'(sat_inc(CNT_MAX_W'(err_data_cnt), CNT_MAX_W'(data_bad), CNT_WIDTH));
      err_len_cnt  <= CNT_WIDTH'(sat_inc(CNT_MAX_W'(err_len_cnt), CNT_MAX_W'(len_bad), CNT_WIDTH));
      err_keep_cnt <= CNT_WIDTH'(sat_inc(CNT_MAX_W'(err_keep_cnt), CNT_MAX_W'(keep_bad), CNT_WIDTH));
      err_sticky   <= err_sticky | data_bad | len_bad | keep_bad;
    end
  end

endmodule

// File: tb/tb_test_axis_rx_chk.sv
// Bench for test_axis_rx_chk: directed and randomized frames against a frame-level model.
module tb_test_axis_rx_chk;

  localparam int unsigned KB   = 8;
  localparam int unsigned SIZE = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic stat_clr;

  // dut0: free-running ready, 64-bit
  logic [63:0] d0_tdata;
  logic [7:0]  d0_tkeep;
  logic        d0_tvalid, d0_tlast, d0_tready;
  logic [31:0] d0_frame, d0_byte, d0_derr, d0_lerr, d0_kerr;
  logic        d0_inf, d0_sticky;

  // dut1: LFSR-throttled ready, 64-bit
  logic [63:0] d1_tdata;
  logic [7:0]  d1_tkeep;
  logic        d1_tvalid, d1_tlast, d1_tready;
  logic [31:0] d1_frame, d1_byte, d1_derr, d1_lerr, d1_kerr;
  logic        d1_inf, d1_sticky;

  // dut2: 8-bit, 4-bit counters, data check off
  logic [7:0]  d2_tdata;
  logic [0:0]  d2_tkeep;
  logic        d2_tvalid, d2_tlast, d2_tready;
  logic [3:0]  d2_frame, d2_byte, d2_derr, d2_lerr, d2_kerr;
  logic        d2_inf, d2_sticky;

  test_axis_rx_chk #(.AXIS_DATA_WIDTH(64), .TEST_RX_SIZE(1024), .CNT_WIDTH(32),
                     .READY_MODE(0), .CHECK_DATA(1)) dut0 (
    .clk(clk), .rstn(rstn), .rx_axis_tdata(d0_tdata), .rx_axis_tkeep(d0_tkeep),
    .rx_axis_tvalid(d0_tvalid), .rx_axis_tlast(d0_tlast), .rx_axis_tready(d0_tready),
    .stat_clr(stat_clr), .frame_cnt(d0_frame), .byte_cnt(d0_byte), .err_data_cnt(d0_derr),
    .err_len_cnt(d0_lerr), .err_keep_cnt(d0_kerr), .in_frame(d0_inf), .err_sticky(d0_sticky));

  test_axis_rx_chk #(.AXIS_DATA_WIDTH(64), .TEST_RX_SIZE(1024), .CNT_WIDTH(32),
                     .READY_MODE(1), .CHECK_DATA(1)) dut1 (
    .clk(clk), .rstn(rstn), .rx_axis_tdata(d1_tdata), .rx_axis_tkeep(d1_tkeep),
    .rx_axis_tvalid(d1_tvalid), .rx_axis_tlast(d1_tlast), .rx_axis_tready(d1_tready),
    .stat_clr(stat_clr), .frame_cnt(d1_frame), .byte_cnt(d1_byte), .err_data_cnt(d1_derr),
    .err_len_cnt(d1_lerr), .err_keep_cnt(d1_kerr), .in_frame(d1_inf), .err_sticky(d1_sticky));

  test_axis_rx_chk #(.AXIS_DATA_WIDTH(8), .TEST_RX_SIZE(2), .CNT_WIDTH(4),
                     .READY_MODE(0), .CHECK_DATA(0)) dut2 (
    .clk(clk), .rstn(rstn), .rx_axis_tdata(d2_tdata), .rx_axis_tkeep(d2_tkeep),
    .rx_axis_tvalid(d2_tvalid), .rx_axis_tlast(d2_tlast), .rx_axis_tready(d2_tready),
    .stat_clr(stat_clr), .frame_cnt(d2_frame), .byte_cnt(d2_byte), .err_data_cnt(d2_derr),
    .err_len_cnt(d2_lerr), .err_keep_cnt(d2_kerr), .in_frame(d2_inf), .err_sticky(d2_sticky));

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Reference model state (frame-level bookkeeping)
  int unsigned m_frames, m_bytes, m_derr, m_lerr, m_kerr, m_beat;
  bit          m_inf, m_sticky;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_frames = 0; m_bytes = 0; m_derr = 0; m_lerr = 0; m_kerr = 0; m_sticky = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_beat = 0; m_inf = 0;
  endtask

  // Apply one accepted beat to the model using the frame rules.
  task automatic model_beat(input logic [63:0] data, input logic [7:0] keep, input bit last);
    int unsigned pop, off;
    bit bad;
    pop = 0; bad = 0; off = m_beat * KB;
    for (int i = 0; i < KB; i++) begin
      if (keep[i]) begin
        pop++;
        if (data[8*i +: 8] != 8'((off + i) % 256)) bad = 1;
      end
    end
    if (bad) begin m_derr++; m_sticky = 1; end
    if (last ? (keep == 8'h00 || keep != 8'((1 << pop) - 1)) : (keep != 8'hFF)) begin
      m_kerr++; m_sticky = 1;
    end
    m_bytes += pop;
    if (last) begin
      if (off + pop != SIZE) begin m_lerr++; m_sticky = 1; end
      m_frames++; m_beat = 0; m_inf = 0;
    end else begin
      m_beat++; m_inf = 1;
    end
  endtask

  function automatic logic [63:0] good_data(input int unsigned beat);
    logic [63:0] d;
    for (int i = 0; i < KB; i++) d[8*i +: 8] = 8'(beat * KB + i);
    return d;
  endfunction

  task automatic chk0(input string tag);
    chk({tag, ":frame"},  64'(d0_frame),  64'(m_frames));
    chk({tag, ":bytes"},  64'(d0_byte),   64'(m_bytes));
    chk({tag, ":derr"},   64'(d0_derr),   64'(m_derr));
    chk({tag, ":lerr"},   64'(d0_lerr),   64'(m_lerr));
    chk({tag, ":kerr"},   64'(d0_kerr),   64'(m_kerr));
    chk({tag, ":infr"},   64'(d0_inf),    64'(m_inf));
    chk({tag, ":sticky"}, 64'(d0_sticky), 64'(m_sticky));
    chk({tag, ":tready"}, 64'(d0_tready), 64'd1);
  endtask

  task automatic chk1(input string tag);
    chk({tag, ":frame"},  64'(d1_frame),  64'(m_frames));
    chk({tag, ":bytes"},  64'(d1_byte),   64'(m_bytes));
    chk({tag, ":derr"},   64'(d1_derr),   64'(m_derr));
    chk({tag, ":lerr"},   64'(d1_lerr),   64'(m_lerr));
    chk({tag, ":kerr"},   64'(d1_kerr),   64'(m_kerr));
    chk({tag, ":infr"},   64'(d1_inf),    64'(m_inf));
    chk({tag, ":sticky"}, 64'(d1_sticky), 64'(m_sticky));
  endtask

  // One beat into dut0, with an occasional idle cycle carrying junk first.
  task automatic send0(input logic [63:0] data, input logic [7:0] keep, input bit last, input bit clr);
    if ($urandom_range(0, 3) == 0) begin
      d0_tvalid = 1'b0;
      d0_tdata  = {$urandom, $urandom};
      d0_tkeep  = 8'($urandom);
      d0_tlast  = 1'($urandom);
      @(posedge clk); #1;
      chk0("idle");
    end
    d0_tvalid = 1'b1; d0_tdata = data; d0_tkeep = keep; d0_tlast = last; stat_clr = clr;
    @(posedge clk); #1;
    d0_tvalid = 1'b0; stat_clr = 1'b0;
    model_beat(data, keep, last);
    if (clr) model_clear();
    chk0("beat");
  endtask

  task automatic send_frame0(input int unsigned nbeats, input logic [7:0] last_keep);
    for (int b = 0; b < nbeats; b++) begin
      send0(good_data(b), (b == nbeats - 1) ? last_keep : 8'hFF, b == nbeats - 1, 1'b0);
    end
  endtask

  task automatic clear_stats();
    d0_tvalid = 1'b0; stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    model_clear();
    chk0("clr");
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] data;
    logic [7:0]  keep;
    logic [7:0]  keep_tab [7];
    int unsigned nb, cycles, ready_hi;
    bit          rdy, accepted, abort;

    keep_tab[0] = 8'hFF; keep_tab[1] = 8'h0F; keep_tab[2] = 8'h01; keep_tab[3] = 8'h7F;
    keep_tab[4] = 8'h05; keep_tab[5] = 8'h00; keep_tab[6] = 8'h3F;

    rstn = 1'b0; stat_clr = 1'b0;
    d0_tdata = '0; d0_tkeep = '0; d0_tvalid = 1'b0; d0_tlast = 1'b0;
    d1_tdata = '0; d1_tkeep = '0; d1_tvalid = 1'b0; d1_tlast = 1'b0;
    d2_tdata = '0; d2_tkeep = '0; d2_tvalid = 1'b0; d2_tlast = 1'b0;
    model_reset();

    // Reset state: everything zero including tready
    repeat (3) @(posedge clk);
    #1;
    chk("rst:d0_tready", 64'(d0_tready), 64'd0);
    chk("rst:d1_tready", 64'(d1_tready), 64'd0);
    chk("rst:d0_frame",  64'(d0_frame),  64'd0);
    chk("rst:d0_bytes",  64'(d0_byte),   64'd0);
    chk("rst:d0_errs",   64'(d0_derr | d0_lerr | d0_kerr), 64'd0);
    chk("rst:d0_inf",    64'(d0_inf),    64'd0);
    chk("rst:d0_sticky", 64'(d0_sticky), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk0("rel");

    // Good 1024-byte frame
    send_frame0(128, 8'hFF);
    chk("t1:frame", 64'(d0_frame), 64'd1);
    chk("t1:bytes", 64'(d0_byte), 64'd1024);
    chk("t1:errs",  64'(d0_derr + d0_lerr + d0_kerr), 64'd0);
    chk("t1:sticky", 64'(d0_sticky), 64'd0);

    // 1020-byte frame with legal short last beat
    clear_stats();
    send_frame0(128, 8'h0F);
    chk("t2:lerr",  64'(d0_lerr), 64'd1);
    chk("t2:kerr",  64'(d0_kerr), 64'd0);
    chk("t2:bytes", 64'(d0_byte), 64'd1020);

    // Beat 5 lane 3 zeroed (expected 0x2B)
    clear_stats();
    for (int b = 0; b < 128; b++) begin
      data = good_data(b);
      if (b == 5) data[31:24] = 8'h00;
      send0(data, 8'hFF, b == 127, 1'b0);
      if (b == 5) begin
        chk("t3:derr", 64'(d0_derr), 64'd1);
        chk("t3:sticky", 64'(d0_sticky), 64'd1);
      end
    end
    chk("t3:derr_end", 64'(d0_derr), 64'd1);

    // Illegal keep on non-last and last beats
    clear_stats();
    send0(good_data(0), 8'h7F, 1'b0, 1'b0);
    send0(good_data(1), 8'h05, 1'b1, 1'b0);
    chk("t4:kerr", 64'(d0_kerr), 64'd2);
    chk("t4:lerr", 64'(d0_lerr), 64'd1);
    chk("t4:bytes", 64'(d0_byte), 64'd9);

    // stat_clr with a same-cycle tlast xfer, then clr mid-frame leaves beat position alone
    clear_stats();
    send_frame0(3, 8'hFF);
    for (int b = 0; b < 3; b++) send0(good_data(b), 8'hFF, 1'b0, 1'b0);
    send0(good_data(3), 8'hFF, 1'b1, 1'b1);
    chk("t5:frame", 64'(d0_frame), 64'd0);
    chk("t5:lerr",  64'(d0_lerr), 64'd0);
    chk("t5:inf",   64'(d0_inf), 64'd0);
    for (int b = 0; b < 50; b++) send0(good_data(b), 8'hFF, 1'b0, 1'b0);
    clear_stats();
    chk("t5:inf_kept", 64'(d0_inf), 64'd1);
    for (int b = 50; b < 128; b++) send0(good_data(b), 8'hFF, b == 127, 1'b0);
    chk("t5:frame2", 64'(d0_frame), 64'd1);
    chk("t5:lerr2",  64'(d0_lerr), 64'd0);

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      nb = ($urandom_range(0, 1) == 1) ? 128 : $urandom_range(1, 130);
      for (int b = 0; b < nb; b++) begin
        data = good_data(b);
        if ($urandom_range(0, 9) == 0) data = data ^ (64'd1 << $urandom_range(0, 63));
        if (b == nb - 1) keep = ($urandom_range(0, 1) == 1) ? keep_tab[$urandom_range(0, 6)] : 8'hFF;
        else keep = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'hFF;
        send0(data, keep, b == nb - 1, 1'b0);
      end
    end

    // Reset mid-frame drops the partial frame
    clear_stats();
    for (int b = 0; b < 40; b++) send0(good_data(b), 8'hFF, 1'b0, 1'b0);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("t7:tready", 64'(d0_tready), 64'd0);
    chk("t7:inf",    64'(d0_inf), 64'd0);
    rstn = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk0("t7:rel");
    send_frame0(128, 8'hFF);
    chk("t7:frame", 64'(d0_frame), 64'd1);
    chk("t7:lerr",  64'(d0_lerr), 64'd0);

    // Throttled ready, tvalid held high for 10 frames
    model_reset();
    chk1("t8:start");
    cycles = 0; ready_hi = 0; abort = 0;
    d1_tvalid = 1'b1;
    for (int f = 0; f < 10 && !abort; f++) begin
      for (int b = 0; b < 128 && !abort; b++) begin
        d1_tdata = good_data(b); d1_tkeep = 8'hFF; d1_tlast = (b == 127);
        accepted = 0;
        while (!accepted && cycles < 20000) begin
          rdy = d1_tready;
          @(posedge clk); #1;
          cycles++;
          if (rdy) begin
            ready_hi++;
            model_beat(d1_tdata, d1_tkeep, d1_tlast);
            accepted = 1;
          end
          chk1("t8");
        end
        if (!accepted) begin
          chk("t8:timeout", 64'd0, 64'(accepted));
          abort = 1;
        end
      end
    end
    d1_tvalid = 1'b0;
    chk("t8:frame",  64'(d1_frame), 64'd10);
    chk("t8:bytes",  64'(d1_byte), 64'd10240);
    chk("t8:errs",   64'(d1_derr + d1_lerr + d1_kerr), 64'd0);
    chk("t8:duty_lo", 64'(ready_hi * 100 >= cycles * 70), 64'd1);
    chk("t8:duty_hi", 64'(ready_hi * 100 <= cycles * 80), 64'd1);

    // Small counters saturate; data check disabled
    d2_tvalid = 1'b1; d2_tkeep = 1'b1; d2_tlast = 1'b0; d2_tdata = 8'($urandom);
    @(posedge clk); #1;
    d2_tlast = 1'b1; d2_tdata = 8'($urandom);
    @(posedge clk); #1;
    chk("t9:frame", 64'(d2_frame), 64'd1);
    chk("t9:bytes", 64'(d2_byte), 64'd2);
    chk("t9:lerr",  64'(d2_lerr), 64'd0);
    chk("t9:sticky", 64'(d2_sticky), 64'd0);
    d2_tkeep = 1'b0;
    @(posedge clk); #1;
    chk("t9:kerr",  64'(d2_kerr), 64'd1);
    chk("t9:lerr1", 64'(d2_lerr), 64'd1);
    chk("t9:bytes1", 64'(d2_byte), 64'd2);
    d2_tkeep = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      d2_tdata = 8'($urandom);
      @(posedge clk); #1;
      chk("t9:sat_frame", 64'(d2_frame), 64'((2 + k > 15) ? 15 : 2 + k));
      chk("t9:sat_bytes", 64'(d2_byte),  64'((2 + k > 15) ? 15 : 2 + k));
      chk("t9:sat_lerr",  64'(d2_lerr),  64'((1 + k > 15) ? 15 : 1 + k));
      chk("t9:derr",      64'(d2_derr),  64'd0);
    end
    d2_tvalid = 1'b0;
    chk("t9:inf",    64'(d2_inf), 64'd0);
    chk("t9:tready", 64'(d2_tready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
